// File: rtl/lsu_pkg.sv
// Shared types, size codes and sizing for the load/store unit and its lane helper.
// Optional feature macro used by lsu: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam int unsigned ADDR_SIZE    = 12;
  localparam int unsigned WORD_SIZE_B  = 4;
  localparam int unsigned DATA_W       = 8 * WORD_SIZE_B;
  localparam int unsigned RAM_CAPACITY = 256;

  localparam logic [2:0] LSU_SZ_B  = 3'b000;
  localparam logic [2:0] LSU_SZ_H  = 3'b001;
  localparam logic [2:0] LSU_SZ_W  = 3'b010;
  localparam logic [2:0] LSU_SZ_BU = 3'b100;
  localparam logic [2:0] LSU_SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Unsigned variants only exist for loads; the funct3 gaps are never legal.
  function automatic logic size_illegal(input logic [2:0] size, input logic wr);
    return (size == 3'b011) || (size[2:1] == 2'b11) || (size[2] && wr);
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
    return ((size[1:0] == 2'b01) && lane[0]) || ((size[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane handling: extract and extend load data, merge sub-word store data
// into the word read back from ram.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]        size,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_data
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  always_comb begin
    shamt   = {lane, 3'b000};
    shifted = word >> shamt;

    case (size)
      LSU_SZ_B:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      LSU_SZ_BU: load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LSU_SZ_H:  load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      LSU_SZ_HU: load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase

    // Only byte and half stores take this path; size[0] tells them apart.
    mask       = (size[0] ? DATA_W'(32'h0000_FFFF) : DATA_W'(32'h0000_00FF)) << shamt;
    store_data = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the CPU execute stage and a word-wide ram with Cs/We/Ack handshake.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of issuing them unaligned.
module lsu
  import lsu_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Req,
  input  logic                 Wr,
  input  logic [2:0]           Size,
  input  logic [ADDR_SIZE-1:0] Addr,
  input  logic [DATA_W-1:0]    Wdata,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATA_W-1:0]    Rdata,
  output logic                 Err,
  output logic [ADDR_SIZE-1:0] Ram_addr,
  output logic                 Ram_cs,
  output logic                 Ram_we,
  output logic [DATA_W-1:0]    Ram_wdata,
  input  logic [DATA_W-1:0]    Ram_rdata,
  input  logic                 Ram_ack
);

  localparam int unsigned AW1 = ADDR_SIZE + 1;

  state_t                 state;
  logic                   wr_q;
  logic [2:0]             size_q;
  logic [1:0]             lane_q;
  logic [DATA_W-1:0]      wdata_q;

  logic [ADDR_SIZE:0]     req_end;
  logic                   out_of_range;
  logic                   reject;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [1:0]             req_lane;
  logic [DATA_W-1:0]      load_data;
  logic [DATA_W-1:0]      store_data;

  always_comb begin
    req_end      = {1'b0, Addr} + {{(ADDR_SIZE-2){1'b0}}, size_bytes(Size)};
    out_of_range = req_end > AW1'(RAM_CAPACITY);
`ifdef LSU_MISALIGN_TRAP_EN
    reject       = size_illegal(Size, Wr) || out_of_range || is_misaligned(Size, Addr[1:0]);
    req_addr     = {Addr[ADDR_SIZE-1:2], 2'b00};
    req_lane     = Addr[1:0];
`else
    // Byte-granular ram: the unaligned address goes straight out and data sits in lane 0.
    reject       = size_illegal(Size, Wr) || out_of_range;
    req_addr     = Addr;
    req_lane     = '0;
`endif
  end

  lsu_lane u_lane (
    .size       (size_q),
    .lane       (lane_q),
    .word       (Ram_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      Rdata     <= '0;
      Ram_addr  <= '0;
      Ram_cs    <= 1'b0;
      Ram_we    <= 1'b0;
      Ram_wdata <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req) begin
            wr_q    <= Wr;
            size_q  <= Size;
            lane_q  <= req_lane;
            wdata_q <= Wdata;
            if (reject) begin
              Err   <= 1'b1;
              Done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              Busy     <= 1'b1;
              Err      <= 1'b0;
              Ram_cs   <= 1'b1;
              Ram_addr <= req_addr;
              if (Wr && (Size == LSU_SZ_W)) begin
                Ram_we    <= 1'b1;
                Ram_wdata <= Wdata;
                state     <= ST_WRITE;
              end else begin
                Ram_we <= 1'b0;
                state  <= ST_READ;
              end
            end
          end
        end

        ST_READ: begin
          if (Ram_ack) begin
            if (!wr_q) begin
              Rdata  <= load_data;
              Ram_cs <= 1'b0;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              // Cs stays high; the ram drops Ack this edge and acks the write one edge later.
              Ram_wdata <= store_data;
              Ram_we    <= 1'b1;
              state     <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          if (Ram_ack) begin
            Ram_cs <= 1'b0;
            Ram_we <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          Done  <= 1'b0;
          Err   <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-granular ram model plus a byte-array reference of memory contents.
module tb_lsu;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Req = 1'b0;
  logic        Wr = 1'b0;
  logic [2:0]  Size = 3'b000;
  logic [11:0] Addr = '0;
  logic [31:0] Wdata = '0;
  logic        Busy, Done, Err, Ram_cs, Ram_we;
  logic [31:0] Rdata, Ram_wdata;
  logic [11:0] Ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  logic [7:0]  mem      [256];
  logic [7:0]  init_mem [256];
  logic [7:0]  ref_mem  [256];
  bit          mem_loaded;
  logic [31:0] exp_rdata;
  int          checks = 0;
  int          errors = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 Clk = ~Clk;

  lsu dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Size(Size), .Addr(Addr), .Wdata(Wdata),
    .Busy(Busy), .Done(Done), .Rdata(Rdata), .Err(Err),
    .Ram_addr(Ram_addr), .Ram_cs(Ram_cs), .Ram_we(Ram_we), .Ram_wdata(Ram_wdata),
    .Ram_rdata(ram_rdata), .Ram_ack(ram_ack)
  );

  // ram: acks the edge after Cs, data valid only with Ack, Cs&Ack clears both.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ram_ack   <= 1'b0;
      ram_rdata <= '0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        mem_loaded <= 1'b1;
      end
    end else if (Ram_cs && ram_ack) begin
      ram_ack   <= 1'b0;
      ram_rdata <= '0;
    end else if (Ram_cs) begin
      if (Ram_we) begin
        for (int i = 0; i < 4; i++) mem[(int'(Ram_addr) + i) % 256] <= Ram_wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < 4; i++) ram_rdata[8*i +: 8] <= mem[(int'(Ram_addr) + i) % 256];
      end
      ram_ack <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic wr, input logic [2:0] sz, input logic [11:0] a,
                       input logic [31:0] wd, output int cyc, output logic cs_seen,
                       output logic busy1, output logic [11:0] cs_addr);
    @(posedge Clk); #1;
    Req = 1'b1; Wr = wr; Size = sz; Addr = a; Wdata = wd;
    cyc = 0; cs_seen = 1'b0; busy1 = 1'b0; cs_addr = '0;
    do begin
      @(posedge Clk); #1;
      Req = 1'b0; Addr = 12'($urandom); Wdata = $urandom;
      cyc++;
      if (cyc == 1) busy1 = Busy;
      if (Ram_cs && !cs_seen) begin cs_seen = 1'b1; cs_addr = Ram_addr; end
    end while (!Done && cyc < 20);
  endtask

  // Expectations come from memory contents as bytes, independent of how the unit sequences ram.
  task automatic run_op(input string tag, input logic wr, input logic [2:0] sz,
                        input int unsigned a, input logic [31:0] wd);
    int unsigned n;
    logic illegal, mis, rej;
    logic [31:0] v;
    int exp_lat, cyc;
    logic cs_seen, busy1;
    logic [11:0] cs_addr;
    logic [11:0] a12;
    a12     = 12'(a);
    n       = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    illegal = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111) || (sz[2] && wr);
    mis     = ((n == 2) && (a % 2 != 0)) || ((n == 4) && (a % 4 != 0));
    rej     = illegal || (a + n > 256) || (TRAP && mis);
    if (rej) exp_lat = 1;
    else if (wr && n < 4) exp_lat = 5;
    else exp_lat = 3;
    if (!rej) begin
      if (wr) begin
        for (int i = 0; i < int'(n); i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(n); i++) v[8*i +: 8] = ref_mem[a + i];
        if (sz == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (sz == 3'b001) v = {{16{v[15]}}, v[15:0]};
        exp_rdata = v;
      end
    end
    do_op(wr, sz, a12, wd, cyc, cs_seen, busy1, cs_addr);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, Err}, {31'b0, rej});
    check({tag, "_rdata"}, Rdata, exp_rdata);
    check({tag, "_cs_seen"}, {31'b0, cs_seen}, {31'b0, !rej});
    check({tag, "_busy"}, {31'b0, busy1}, {31'b0, !rej});
    if (!rej) check({tag, "_ram_addr"}, {20'b0, cs_addr}, {20'b0, TRAP ? (a12 & 12'hFFC) : a12});
    @(posedge Clk); #1;
    check({tag, "_done_pulse"}, {31'b0, Done}, 32'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {27'b0, Busy, Done, Err, Ram_cs, Ram_we}, 32'b0);
    check({tag, "_rdata"}, Rdata, 32'b0);
    check({tag, "_ram_addr"}, {20'b0, Ram_addr}, 32'b0);
    check({tag, "_ram_wdata"}, Ram_wdata, 32'b0);
  endtask

  initial begin
    int cyc, bad;
    logic [2:0] szs [10];
    logic [2:0] sz;
    logic wr;
    int unsigned a;

    for (int i = 0; i < 256; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    exp_rdata = '0;
    #1 Rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b0;

    run_op("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    run_op("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10_const", Rdata, 32'hDEADBEEF);
    run_op("lb_13", 1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_13_const", Rdata, 32'hFFFFFFDE);
    run_op("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_13_const", Rdata, 32'h000000DE);
    run_op("lh_12", 1'b0, 3'b001, 32'h12, 32'h0);
    check("lh_12_const", Rdata, 32'hFFFFDEAD);
    run_op("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0);
    check("lhu_10_const", Rdata, 32'h0000BEEF);
    run_op("sb_11", 1'b1, 3'b000, 32'h11, 32'h0000_0055);
    run_op("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10b_const", Rdata, 32'hDEAD55EF);
    run_op("size_011", 1'b0, 3'b011, 32'h10, 32'h0);
    run_op("lw_cap", 1'b0, 3'b010, 254, 32'h0);
    run_op("sw_cap", 1'b1, 3'b010, 254, 32'h1234_5678);
    run_op("sbu_ill", 1'b1, 3'b100, 32'h20, 32'hFF);
    run_op("lb_last", 1'b0, 3'b000, 255, 32'h0);
    run_op("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10c_const", Rdata, 32'hDEAD55EF);
    run_op("lw_11", 1'b0, 3'b010, 32'h11, 32'h0);
    run_op("sh_22", 1'b1, 3'b001, 32'h22, 32'hAAAA_C3A5);
    run_op("lw_20", 1'b0, 3'b010, 32'h20, 32'h0);

    // Reset while the sub-word store sits in WRITE, before the ram commits it.
    @(posedge Clk); #1;
    Req = 1'b1; Wr = 1'b1; Size = 3'b001; Addr = 12'h020; Wdata = 32'h0000_BEEF;
    cyc = 0;
    do begin
      @(posedge Clk); #1;
      Req = 1'b0; cyc++;
    end while (!Ram_we && cyc < 10);
    check("sh_reached_write", {31'b0, Ram_we}, 32'd1);
    #2 Rst = 1'b1;
    #1 check_reset_outputs("midop_reset");
    exp_rdata = '0;
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b0;
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h20, 32'h0);

    szs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
    for (int k = 0; k < 80; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = szs[$urandom_range(0, 9)];
      a  = $urandom_range(0, 259);
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      run_op("rand", wr, sz, a, $urandom);
    end

    @(posedge Clk); #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_final_bad_bytes", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
